// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction memory. Consumes a byte stream from the
//   host (LEN_HI, LEN_LO, LEN*4 big-endian data bytes, XOR checksum byte),
//   writes each assembled 32-bit instruction word to the instruction memory at
//   BASE_ADDR + 4*index, and keeps the CPU held until the whole image has been
//   loaded and its checksum verified.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   1-cycle pulse, begins a load (only from IDLE, DONE or ERR)
//   in_valid   in   in_byte is valid
//   in_byte    in   stream byte
//   in_ready   out  loader takes a byte this cycle (transfer = in_valid & in_ready)
//   imem_we    out  instruction memory write strobe, one cycle per word
//   imem_addr  out  byte address of the write (held between writes)
//   imem_wdata out  instruction word (held between writes)
//   cpu_run    out  CPU may execute (only once the image is loaded and verified)
//   busy       out  load in progress
//   done       out  image loaded, checksum good (sticky until next start)
//   error      out  length or checksum fault (sticky until next start)
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_run,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int IDX_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_reg;
  logic [7:0]       len_hi_reg;
  logic [IDX_W-1:0] len_reg;
  logic [IDX_W-1:0] word_idx_reg;
  logic [1:0]       byte_cnt_reg;
  logic [31:0]      asm_reg;
  logic [7:0]       csum_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             error_reg;
  logic             cpu_run_reg;
  logic             imem_we_reg;
  logic [31:0]      imem_addr_reg;
  logic [31:0]      imem_wdata_reg;

  logic        accept;
  logic [16:0] len_full;
  logic        len_over;
  logic        last_word;
  logic [31:0] word_off;

  // The write cycle is a forced bubble: no byte is taken while imem_we is high,
  // so the DATA path never has to handle a byte and a write in the same cycle.
  assign in_ready  = busy_reg & ~imem_we_reg;
  assign accept    = in_valid & in_ready;

  // Length as it will be once the low byte currently on in_byte is taken.
  assign len_full  = {1'b0, len_hi_reg, in_byte};
  assign len_over  = len_full > 17'(DEPTH);
  assign last_word = (word_idx_reg == len_reg - IDX_W'(1));
  assign word_off  = 32'(word_idx_reg) << 2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      len_hi_reg     <= '0;
      len_reg        <= '0;
      word_idx_reg   <= '0;
      byte_cnt_reg   <= '0;
      asm_reg        <= '0;
      csum_reg       <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      cpu_run_reg    <= 1'b0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
    end else begin
      imem_we_reg <= 1'b0;

      case (state_reg)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_reg    <= S_LEN_HI;
            busy_reg     <= 1'b1;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            cpu_run_reg  <= 1'b0;
            len_hi_reg   <= '0;
            len_reg      <= '0;
            word_idx_reg <= '0;
            byte_cnt_reg <= '0;
            asm_reg      <= '0;
            csum_reg     <= '0;
          end
        end

        S_LEN_HI: begin
          if (accept) begin
            len_hi_reg <= in_byte;
            state_reg  <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (accept) begin
            if (len_over) begin
              state_reg <= S_ERR;
              busy_reg  <= 1'b0;
              error_reg <= 1'b1;
            end else if (len_full == 17'd0) begin
              // Empty image: only the checksum byte (expected 0x00) follows.
              state_reg <= S_CSUM;
            end else begin
              len_reg   <= len_full[IDX_W-1:0];
              state_reg <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            asm_reg      <= {asm_reg[23:0], in_byte};
            csum_reg     <= csum_reg ^ in_byte;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              imem_we_reg    <= 1'b1;
              imem_wdata_reg <= {asm_reg[23:0], in_byte};
              imem_addr_reg  <= BASE_ADDR + word_off;
              word_idx_reg   <= word_idx_reg + IDX_W'(1);
              if (last_word) begin
                state_reg <= S_CSUM;
              end
            end
          end
        end

        S_CSUM: begin
          if (accept) begin
            busy_reg <= 1'b0;
            if (in_byte == csum_reg) begin
              state_reg   <= S_DONE;
              done_reg    <= 1'b1;
              cpu_run_reg <= 1'b1;
            end else begin
              state_reg <= S_ERR;
              error_reg <= 1'b1;
            end
          end
        end

        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_we    = imem_we_reg;
  assign imem_addr  = imem_addr_reg;
  assign imem_wdata = imem_wdata_reg;
  assign cpu_run    = cpu_run_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error      = error_reg;

endmodule
